lane_hit_judge: RTL and testbench
=================================

# lane_hit_judge

Parametrised N-lane note-hit judge for the Guitar Hero datapath. Sits between the chart pattern reader, the controller buttons and the screen/score display. It debounces the raw controller buttons and tracks, per lane, whether a note is waiting at the strike line. It classifies each lane event as hit, miss or ghost press, and maintains a streak, a multiplier and a saturating score.

## Interface
Parameters:
- LANES, 4, number of note lanes/buttons
- WINDOW, 8, late-hit window in ticks after a note arrives (1..255)
- DEBOUNCE, 16, clock cycles a synchronised button level must stay stable before it is accepted (1..65535)
- STREAK_STEP, 10, streak hits per multiplier step
- POINTS, 50, base points per hit
- SCORE_W, 20, score width
- STREAK_W, 10, streak width

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- clear  in  1  synchronous song restart
- tick  in  1  one-cycle chart-advance strobe
- note_valid  in  1  note_lanes is meaningful on this tick
- note_lanes  in  LANES  lanes whose note reaches the strike line on this tick
- btn_n  in  LANES  raw active-low lane buttons, asynchronous
- btn_held  out  LANES  debounced pressed level, active-high
- hit  out  LANES  one-cycle hit pulse per lane
- miss  out  LANES  one-cycle miss pulse per lane
- ghost  out  LANES  one-cycle press-with-no-note pulse per lane
- streak  out  STREAK_W  consecutive-hit count
- multiplier  out  3  current multiplier, 1..4
- score  out  SCORE_W  accumulated score

## Operation
- Per-lane button path:
  - 2-FF synchroniser, reset value 1 (released).
  - Debounce counter: the accepted level changes only after the synchronised level has differed from it for DEBOUNCE consecutive cycles. Any bounce restarts the count.
  - press_evt: internal one-cycle pulse on the accepted released→pressed transition. Release generates no event.
- Per-lane FSM, states IDLE and ARMED, with a window counter wcnt of width clog2(WINDOW+1):
  - IDLE, tick & note_valid & note_lanes[i] → ARMED, wcnt=0.
  - IDLE, press_evt → ghost[i]; stays IDLE.
  - ARMED, press_evt → hit[i], then IDLE.
  - ARMED, each tick → wcnt+1. When wcnt reaches WINDOW without a press → miss[i], then IDLE.
- Same-cycle conflicts in ARMED:
  - Press and expiry in the same cycle: hit wins; no miss.
  - New note on tick, no press: miss[i] for the old note; re-ARM with wcnt=0.
  - New note on tick with press: hit[i] for the old note; re-ARM with wcnt=0.
- Multiplier: min(1 + streak/STREAK_STEP, 4), computed from the registered streak.
- Score/streak update, using the registered hit/miss/ghost pulses, with h = popcount(hit):
  - score += h·POINTS·multiplier, using the pre-update multiplier.
  - Score saturates at all-ones.
  - If any miss or ghost bit is set: streak ← 0, and hits in that cycle still score.
  - Otherwise streak += h, saturating at all-ones.
- clear:
  - Forces every FSM to IDLE, zeroes score and streak, suppresses pulses that cycle, and discards events arriving in that cycle.
  - Synchroniser and debouncer state are untouched, so btn_held keeps its value.
- RESET:
  - Asynchronous; clears everything, including the synchronisers, whose reset value is 1.
  - Reset values: btn_held=0, hit=miss=ghost=0, streak=0, multiplier=1, score=0.

## Timing
- Clean btn_n falling edge at cycle 0 → btn_held rises at cycle DEBOUNCE+2; press_evt fires the same cycle.
- hit/miss/ghost are registered, asserted the cycle after the press_evt or tick that causes them, for exactly one cycle.
- streak, multiplier and score update the cycle after the pulses (event + 2).
- A miss from window expiry appears the cycle after the WINDOW-th tick following arming.
- tick may occur on any cycle, including back-to-back cycles; no handshake.
- Lanes are fully independent; multiple lanes may pulse in the same cycle.

## Test plan
- **Reset:** RESET mid-operation with lanes ARMED and score=500 → all outputs at reset values immediately (asynchronous); no pulses after release.
- **Debounce:** DEBOUNCE=4, btn_n lane 0 bounces 0/1 every 2 cycles, then holds 0 → btn_held[0] rises exactly 6 cycles after the last 1→0 edge; a single ghost[0] pulse.
- **Hit and scoring:** note on lane 1, press 3 ticks later → hit[1]=1 for one cycle; score 0→50, streak 0→1 one cycle later. Twenty such hits with STREAK_STEP=10 → multiplier reads 3 after hit 20; hit 21 adds 150.
- **Expiry:** WINDOW=2, note on lane 2, no press → miss[2] one cycle after the 2nd following tick; streak with a prior value of 7 → 0.
- **Conflicts:**
  - Press coinciding with the expiry tick → hit only.
  - New note on an ARMED lane without press → miss, then re-armed; a later press → hit.
- **Multi-lane and saturation:** hits on lanes 0, 1 and 3 in the same cycle with multiplier 2 → score += 300. With score preloaded near max via repeated hits (SCORE_W=10) → score holds at 1023.

Source files
------------

// File: rtl/lane_hit_judge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lane_hit_judge
//  Purpose  : N-lane note-hit judge. Debounces the raw controller buttons,
//             tracks per lane whether a note is waiting at the strike line,
//             classifies lane events as hit / miss / ghost press and keeps a
//             streak, a multiplier and a saturating score.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK         in   1         system clock
//    RESET       in   1         asynchronous active-high reset
//    clear       in   1         synchronous song restart
//    tick        in   1         one-cycle chart-advance strobe
//    note_valid  in   1         note_lanes is meaningful on this tick
//    note_lanes  in   LANES     lanes whose note reaches the strike line
//    btn_n       in   LANES     raw active-low buttons (asynchronous)
//    btn_held    out  LANES     debounced pressed level (active-high)
//    hit         out  LANES     one-cycle hit pulse per lane
//    miss        out  LANES     one-cycle miss pulse per lane
//    ghost       out  LANES     one-cycle press-without-note pulse per lane
//    streak      out  STREAK_W  consecutive-hit count (saturating)
//    multiplier  out  3         current multiplier, 1..4
//    score       out  SCORE_W   accumulated score (saturating)
// ============================================================================
module lane_hit_judge #(
    parameter int LANES       = 4,
    parameter int WINDOW      = 8,
    parameter int DEBOUNCE    = 16,
    parameter int STREAK_STEP = 10,
    parameter int POINTS      = 50,
    parameter int SCORE_W     = 20,
    parameter int STREAK_W    = 10
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                clear,
    input  logic                tick,
    input  logic                note_valid,
    input  logic [LANES-1:0]    note_lanes,
    input  logic [LANES-1:0]    btn_n,
    output logic [LANES-1:0]    btn_held,
    output logic [LANES-1:0]    hit,
    output logic [LANES-1:0]    miss,
    output logic [LANES-1:0]    ghost,
    output logic [STREAK_W-1:0] streak,
    output logic [2:0]          multiplier,
    output logic [SCORE_W-1:0]  score
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_WCNT_W = $clog2(WINDOW + 1);
    localparam int c_DB_W   = $clog2(DEBOUNCE + 1);
    localparam int c_HC_W   = $clog2(LANES + 1);
    localparam int c_ADD_W  = $clog2(LANES * POINTS * 4 + 1);
    localparam int c_SUM_W  = ((SCORE_W > c_ADD_W) ? SCORE_W : c_ADD_W) + 1;
    localparam int c_STK_W  = ((STREAK_W > c_HC_W) ? STREAK_W : c_HC_W) + 1;

    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE  = c_WCNT_W'(1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WINDOW - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE - 1);

    localparam int c_MULT2_AT = STREAK_STEP;
    localparam int c_MULT3_AT = 2 * STREAK_STEP;
    localparam int c_MULT4_AT = 3 * STREAK_STEP;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } lane_state_t;

    // A lane is offered a new note only on a valid chart tick.
    logic [LANES-1:0] w_new_note;
    assign w_new_note = {LANES{tick & note_valid}} & note_lanes;

    // ------------------------------------------------------------------------
    // Per-lane button conditioning and hit/miss/ghost state machine
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic              r_sync1;
            logic              r_sync2;
            logic              r_level_n;    // accepted (debounced) raw level
            logic [c_DB_W-1:0] r_db_cnt;
            logic              r_press_evt;

            lane_state_t         r_state;
            logic [c_WCNT_W-1:0] r_wcnt;
            logic                r_hit;
            logic                r_miss;
            logic                r_ghost;

            // Synchroniser + debouncer. Untouched by clear so btn_held keeps
            // its value across a song restart.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    r_sync1     <= 1'b1;
                    r_sync2     <= 1'b1;
                    r_level_n   <= 1'b1;
                    r_db_cnt    <= '0;
                    r_press_evt <= 1'b0;
                end else begin
                    r_sync1     <= btn_n[gi];
                    r_sync2     <= r_sync1;
                    r_press_evt <= 1'b0;
                    if (r_sync2 != r_level_n) begin
                        // DEBOUNCE consecutive differing samples accept the
                        // new level; a matching sample restarts the count.
                        if (r_db_cnt == c_DB_LAST) begin
                            r_level_n   <= r_sync2;
                            r_db_cnt    <= '0;
                            r_press_evt <= ~r_sync2;   // only on press
                        end else begin
                            r_db_cnt <= r_db_cnt + c_DB_ONE;
                        end
                    end else begin
                        r_db_cnt <= '0;
                    end
                end
            end

            assign btn_held[gi] = ~r_level_n;

            // Lane FSM. A press always wins over a window expiry, and a new
            // note on an armed lane closes out the old note (hit if pressed,
            // miss otherwise) before re-arming.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    r_state <= S_IDLE;
                    r_wcnt  <= '0;
                    r_hit   <= 1'b0;
                    r_miss  <= 1'b0;
                    r_ghost <= 1'b0;
                end else begin
                    r_hit   <= 1'b0;
                    r_miss  <= 1'b0;
                    r_ghost <= 1'b0;
                    if (clear) begin
                        r_state <= S_IDLE;
                        r_wcnt  <= '0;
                    end else begin
                        case (r_state)
                            S_IDLE: begin
                                if (r_press_evt) begin
                                    r_ghost <= 1'b1;
                                end
                                if (w_new_note[gi]) begin
                                    r_state <= S_ARMED;
                                    r_wcnt  <= '0;
                                end
                            end
                            S_ARMED: begin
                                if (r_press_evt) begin
                                    r_hit <= 1'b1;
                                    if (w_new_note[gi]) begin
                                        r_wcnt <= '0;
                                    end else begin
                                        r_state <= S_IDLE;
                                    end
                                end else if (w_new_note[gi]) begin
                                    r_miss <= 1'b1;
                                    r_wcnt <= '0;
                                end else if (tick) begin
                                    if (r_wcnt == c_WCNT_LAST) begin
                                        r_miss  <= 1'b1;
                                        r_state <= S_IDLE;
                                        r_wcnt  <= '0;
                                    end else begin
                                        r_wcnt <= r_wcnt + c_WCNT_ONE;
                                    end
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_wcnt  <= '0;
                            end
                        endcase
                    end
                end
            end

            assign hit[gi]   = r_hit;
            assign miss[gi]  = r_miss;
            assign ghost[gi] = r_ghost;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Scoring
    // ------------------------------------------------------------------------
    logic [STREAK_W-1:0] r_streak;
    logic [SCORE_W-1:0]  r_score;

    logic [c_HC_W-1:0]   w_hit_cnt;
    logic [2:0]          w_mult;
    logic [c_ADD_W-1:0]  w_add;
    logic [c_SUM_W-1:0]  w_score_sum;
    logic [SCORE_W-1:0]  w_score_nxt;
    logic [c_STK_W-1:0]  w_streak_sum;
    logic [STREAK_W-1:0] w_streak_nxt;
    logic                w_break;

    always_comb begin
        w_hit_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_hit_cnt = w_hit_cnt + c_HC_W'(hit[i]);
        end
    end

    // Multiplier steps every STREAK_STEP hits, capped at 4.
    always_comb begin
        if (int'(r_streak) >= c_MULT4_AT) begin
            w_mult = 3'd4;
        end else if (int'(r_streak) >= c_MULT3_AT) begin
            w_mult = 3'd3;
        end else if (int'(r_streak) >= c_MULT2_AT) begin
            w_mult = 3'd2;
        end else begin
            w_mult = 3'd1;
        end
    end

    always_comb begin
        w_add       = c_ADD_W'(w_hit_cnt) * c_ADD_W'(POINTS) * c_ADD_W'(w_mult);
        w_score_sum = c_SUM_W'(r_score) + c_SUM_W'(w_add);
        if (|w_score_sum[c_SUM_W-1:SCORE_W]) begin
            w_score_nxt = {SCORE_W{1'b1}};
        end else begin
            w_score_nxt = w_score_sum[SCORE_W-1:0];
        end

        w_streak_sum = c_STK_W'(r_streak) + c_STK_W'(w_hit_cnt);
        if (|w_streak_sum[c_STK_W-1:STREAK_W]) begin
            w_streak_nxt = {STREAK_W{1'b1}};
        end else begin
            w_streak_nxt = w_streak_sum[STREAK_W-1:0];
        end

        // Any miss or ghost anywhere breaks the streak; hits that cycle still
        // score at the multiplier in force before the update.
        w_break = |(miss | ghost);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_streak <= '0;
            r_score  <= '0;
        end else if (clear) begin
            r_streak <= '0;
            r_score  <= '0;
        end else begin
            r_score  <= w_score_nxt;
            r_streak <= w_break ? '0 : w_streak_nxt;
        end
    end

    assign streak     = r_streak;
    assign score      = r_score;
    assign multiplier = w_mult;

endmodule
`default_nettype wire

// File: tb/tb_lane_hit_judge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lane_hit_judge
//  Purpose  : Self-checking bench for lane_hit_judge. A cycle-level reference
//             model of the game rules predicts every output each cycle;
//             directed scenarios plus randomized play drive the DUT.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_lane_hit_judge;

    localparam int L    = 4;
    localparam int W    = 4;
    localparam int D    = 4;
    localparam int STEP = 10;
    localparam int PTS  = 50;
    localparam int SW   = 12;
    localparam int KW   = 10;
    localparam int SMAX = (1 << SW) - 1;
    localparam int KMAX = (1 << KW) - 1;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          clear = 1'b0;
    logic          tick = 1'b0;
    logic          note_valid = 1'b0;
    logic [L-1:0]  note_lanes = '0;
    logic [L-1:0]  btn_n = '1;
    logic [L-1:0]  btn_held;
    logic [L-1:0]  hit;
    logic [L-1:0]  miss;
    logic [L-1:0]  ghost;
    logic [KW-1:0] streak;
    logic [2:0]    multiplier;
    logic [SW-1:0] score;

    lane_hit_judge #(
        .LANES(L), .WINDOW(W), .DEBOUNCE(D), .STREAK_STEP(STEP),
        .POINTS(PTS), .SCORE_W(SW), .STREAK_W(KW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .clear(clear), .tick(tick),
        .note_valid(note_valid), .note_lanes(note_lanes), .btn_n(btn_n),
        .btn_held(btn_held), .hit(hit), .miss(miss), .ghost(ghost),
        .streak(streak), .multiplier(multiplier), .score(score)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: game rules stated directly
    // ------------------------------------------------------------------------
    bit m_s1[L], m_s2[L], m_acc[L], m_pe[L];
    bit m_hist[L][$];            // recent synchronised samples per lane
    bit m_armed[L];
    int m_age[L];                // ticks seen since the note arrived
    bit m_hit[L], m_miss[L], m_ghost[L];
    int m_score, m_streak;

    function automatic int exp_mult();
        int m;
        m = 1 + m_streak / STEP;
        return (m > 4) ? 4 : m;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < L; l++) begin
            m_s1[l] = 1; m_s2[l] = 1; m_acc[l] = 1; m_pe[l] = 0;
            m_hist[l].delete();
            m_armed[l] = 0; m_age[l] = 0;
            m_hit[l] = 0; m_miss[l] = 0; m_ghost[l] = 0;
        end
        m_score = 0;
        m_streak = 0;
    endtask

    task automatic model_step();
        int h;
        int s;
        bit brk;
        h = 0;
        brk = 0;
        for (int l = 0; l < L; l++) begin
            h += int'(m_hit[l]);
            brk |= m_miss[l] | m_ghost[l];
        end
        if (clear) begin
            m_score = 0;
            m_streak = 0;
        end else begin
            s = m_score + h * PTS * exp_mult();
            m_score = (s > SMAX) ? SMAX : s;
            if (brk) m_streak = 0;
            else m_streak = (m_streak + h > KMAX) ? KMAX : m_streak + h;
        end
        for (int l = 0; l < L; l++) begin
            bit press, nn, smp, all_diff;
            press = m_pe[l];
            nn = tick && note_valid && note_lanes[l];
            m_hit[l] = 0; m_miss[l] = 0; m_ghost[l] = 0;
            if (clear) begin
                m_armed[l] = 0;
            end else if (!m_armed[l]) begin
                if (press) m_ghost[l] = 1;
                if (nn) begin m_armed[l] = 1; m_age[l] = 0; end
            end else if (press) begin
                m_hit[l] = 1;
                if (nn) m_age[l] = 0; else m_armed[l] = 0;
            end else if (nn) begin
                m_miss[l] = 1;
                m_age[l] = 0;
            end else if (tick) begin
                m_age[l]++;
                if (m_age[l] == W) begin m_miss[l] = 1; m_armed[l] = 0; end
            end
            // Button: accept a level once the last D samples all disagree.
            smp = m_s2[l];
            m_s2[l] = m_s1[l];
            m_s1[l] = btn_n[l];
            m_hist[l].push_back(smp);
            if (m_hist[l].size() > D) void'(m_hist[l].pop_front());
            m_pe[l] = 0;
            all_diff = (m_hist[l].size() == D);
            foreach (m_hist[l][k]) if (m_hist[l][k] == m_acc[l]) all_diff = 0;
            if (all_diff) begin
                m_acc[l] = smp;
                m_pe[l] = (smp == 1'b0);
            end
        end
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) model_reset();
        else model_step();
    end

    always @(negedge CLK) begin
        logic [L-1:0] eh, ehit, emiss, eghost;
        for (int l = 0; l < L; l++) begin
            eh[l] = ~m_acc[l]; ehit[l] = m_hit[l];
            emiss[l] = m_miss[l]; eghost[l] = m_ghost[l];
        end
        if (chk_en) begin
            check_val("btn_held", int'(btn_held), int'(eh));
            check_val("hit", int'(hit), int'(ehit));
            check_val("miss", int'(miss), int'(emiss));
            check_val("ghost", int'(ghost), int'(eghost));
            check_val("streak", int'(streak), m_streak);
            check_val("multiplier", int'(multiplier), exp_mult());
            check_val("score", int'(score), m_score);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 ns after the rising edge)
    // ------------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic note(input logic [L-1:0] m);
        tick = 1; note_valid = 1; note_lanes = m;
        cyc(1);
        tick = 0; note_valid = 0; note_lanes = '0;
    endtask

    task automatic bare_tick();
        tick = 1;
        cyc(1);
        tick = 0;
    endtask

    task automatic press_rel(input logic [L-1:0] m);
        btn_n = btn_n & ~m;
        cyc(D + 4);
        btn_n = btn_n | m;
        cyc(D + 4);
    endtask

    task automatic hits(input logic [L-1:0] m, input int n);
        repeat (n) begin
            note(m);
            press_rel(m);
        end
    endtask

    task automatic do_clear();
        clear = 1;
        cyc(1);
        clear = 0;
    endtask

    int hold[L];

    initial begin
        // Reset
        cyc(1);
        chk_en = 1;
        cyc(2);
        RESET = 0;
        cyc(1);
        check_val("rst_score", int'(score), 0);
        check_val("rst_mult", int'(multiplier), 1);
        check_val("rst_held", int'(btn_held), 0);

        // Debounce with bouncing button on lane 0
        repeat (4) begin
            btn_n[0] = 0; cyc(2);
            btn_n[0] = 1; cyc(2);
        end
        btn_n[0] = 0;
        cyc(D + 1);
        check_val("db_early", int'(btn_held[0]), 0);
        cyc(1);
        check_val("db_rise", int'(btn_held[0]), 1);
        cyc(1);
        check_val("db_ghost", int'(ghost), 1);
        cyc(1);
        check_val("db_ghost_1cyc", int'(ghost), 0);
        btn_n[0] = 1;
        cyc(D + 4);

        // Hit and scoring on lane 1
        do_clear();
        note(4'b0010);
        bare_tick(); bare_tick(); bare_tick();
        press_rel(4'b0010);
        check_val("hit1_score", int'(score), 50);
        check_val("hit1_streak", int'(streak), 1);
        hits(4'b0010, 19);
        check_val("hit20_mult", int'(multiplier), 3);
        check_val("hit20_score", int'(score), 1500);
        hits(4'b0010, 1);
        check_val("hit21_score", int'(score), 1650);

        // Expiry on lane 2 with a prior streak of 7
        do_clear();
        hits(4'b0010, 7);
        check_val("pre_exp_streak", int'(streak), 7);
        note(4'b0100);
        bare_tick(); bare_tick(); bare_tick();
        check_val("exp_early", int'(miss), 0);
        bare_tick();
        check_val("exp_miss", int'(miss), 4);
        cyc(1);
        check_val("exp_streak", int'(streak), 0);
        check_val("exp_score", int'(score), 350);

        // Press coinciding with the expiry tick: hit only
        do_clear();
        note(4'b1000);
        bare_tick(); bare_tick(); bare_tick();
        btn_n[3] = 0;
        cyc(D + 2);
        tick = 1;
        cyc(1);
        tick = 0;
        check_val("cfl_hit", int'(hit), 8);
        check_val("cfl_miss", int'(miss), 0);
        btn_n[3] = 1;
        cyc(D + 4);

        // New note on an armed lane without press: miss, re-arm, then hit
        note(4'b0001);
        note(4'b0001);
        check_val("rearm_miss", int'(miss), 1);
        press_rel(4'b0001);
        check_val("rearm_streak", int'(streak), 1);

        // Multi-lane hit at multiplier 2
        do_clear();
        hits(4'b0001, 10);
        check_val("ml_mult", int'(multiplier), 2);
        note(4'b1011);
        press_rel(4'b1011);
        check_val("ml_score", int'(score), 800);

        // Asynchronous reset mid-operation
        note(4'b0011);
        btn_n[2] = 0;
        cyc(D + 4);
        check_val("pre_rst_held", int'(btn_held[2]), 1);
        @(posedge CLK);
        #3;
        RESET = 1;
        btn_n = '1;
        #1;
        check_val("arst_score", int'(score), 0);
        check_val("arst_mult", int'(multiplier), 1);
        check_val("arst_held", int'(btn_held), 0);
        check_val("arst_pulse", int'(hit | miss | ghost), 0);
        cyc(3);
        RESET = 0;
        cyc(12);
        check_val("post_rst_score", int'(score), 0);

        // Randomized play
        for (int l = 0; l < L; l++) hold[l] = 1;
        for (int c = 0; c < 3000; c++) begin
            tick = ($urandom_range(0, 2) == 0);
            note_valid = ($urandom_range(0, 3) != 0);
            note_lanes = L'($urandom);
            clear = ($urandom_range(0, 149) == 0);
            for (int l = 0; l < L; l++) begin
                hold[l]--;
                if (hold[l] <= 0) begin
                    btn_n[l] = ~btn_n[l];
                    hold[l] = $urandom_range(1, 12);
                end
            end
            cyc(1);
        end
        tick = 0; note_valid = 0; note_lanes = '0; clear = 0;
        btn_n = '1;
        cyc(D + 4);
        do_clear();

        // Score saturation
        hits(4'b1111, 40);
        check_val("sat_score", int'(score), SMAX);
        check_val("sat_streak", int'(streak), 160);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
